hline_sched: RTL and testbench
==============================

HLINE_SCHED -- requirements
Module: hline_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the number of queued line commands (power of 2, range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: clock.
REQ-003 The block SHALL have port nreset, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: software/host offers a line command.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: queue can accept a command.
REQ-006 The block SHALL have ports cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope, cmd_z1, cmd_rem, cmd_err and cmd_rgbx, each input, 32 bits: line descriptor fields.
REQ-007 The block SHALL have port flush, input, 1 bit: discard all queued commands that are not in flight.
REQ-008 The block SHALL have port eng_start, output, 1 bit: start pulse to the hline z-buffer engine.
REQ-009 The block SHALL have ports eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1, eng_rem, eng_err and eng_rgbx, each output, 32 bits: descriptor of the command in flight.
REQ-010 The block SHALL have port eng_done, input, 1 bit: engine done level.
REQ-011 The block SHALL have port busy, output, 1 bit: asserted when state is not IDLE or the queue is non-empty.
REQ-012 The block SHALL have port q_count, output, 5 bits: number of queued entries, including the one in flight.
REQ-013 The block SHALL have port irq, output, 1 bit: sticky flag, set when the queue drains.
REQ-014 The block SHALL have port irq_clr, input, 1 bit: clears irq.
REQ-015 The block SHALL have ports lines_done, output, 16 bits, and busy_cycles, output, 32 bits: statistics counters.

Function
REQ-016 cmd_ready SHALL equal (q_count < DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-017 The queue SHALL push when cmd_valid && cmd_ready; FIFO order; the head SHALL NOT be overwritten while in flight.
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK and WAIT_DONE.
REQ-019 IDLE -> LAUNCH when q_count != 0 and flush = 0; on that transition eng_* SHALL be loaded from the head entry.
REQ-020 In LAUNCH, eng_start = 1 for exactly one cycle; next state SHALL be WAIT_ACK.
REQ-021 WAIT_ACK -> WAIT_DONE when eng_done = 0; this covers an engine parked in its DONE state from a previous line.
REQ-022 WAIT_DONE -> IDLE when eng_done = 1; the head SHALL be popped in the same cycle.
REQ-023 eng_* outputs SHALL remain stable from LAUNCH until the next LAUNCH.
REQ-024 Latency: a push at edge N into an empty, idle block SHALL give eng_start = 1 in the cycle after edge N+1.
REQ-025 A push and a pop in the same cycle SHALL leave q_count unchanged.
REQ-026 flush SHALL drop every entry except an in-flight head (state not IDLE). In that case q_count becomes 1, and after completion becomes 0. Flush in IDLE SHALL give q_count = 0. A push in the same cycle as flush SHALL be discarded.
REQ-027 irq SHALL be set in the cycle a pop leaves q_count = 0 with no simultaneous push. If a set coincides with irq_clr, set SHALL win.
REQ-028 cmd_dx = 0 SHALL be forwarded unchanged; the engine completes it without a burst.
REQ-029 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While nreset = 0 at a clk edge, the block SHALL reset to: state IDLE, pointers 0, q_count 0, eng_start 0, eng_* 0, irq 0, lines_done 0, busy_cycles 0.
REQ-031 A reset mid-line SHALL abandon the in-flight command with no pop and no irq; the engine SHALL be reset by the same nreset.

Configuration
REQ-032 With HLINE_SCHED_STATS_EN defined, lines_done SHALL increment on each pop and saturate at 0xFFFF. busy_cycles SHALL increment each cycle busy = 1 and wrap at 2^32. Both SHALL clear on irq_clr.
REQ-033 Without HLINE_SCHED_STATS_EN, lines_done and busy_cycles SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-034 Scenario: push one command with dx=300 and fb_addr=0x1000; model done after 20 cycles -> eng_start at push+2; eng_fb_addr=0x1000 stable; pop; irq=1; q_count=0.
REQ-035 Scenario: push 5 commands with DEPTH=4 and the engine stalled -> cmd_ready=0 after the 4th; the 5th is accepted only after the first pop; order is preserved by dx=1,2,3,4,5.
REQ-036 Scenario: eng_done held 1 before the second launch -> FSM waits in WAIT_ACK until done falls; no double pop.
REQ-037 Scenario: 3 queued and 1 in flight, flush -> q_count=1; after done, q_count=0 and irq=1; no further eng_start.
REQ-038 Scenario: irq_clr in the same cycle as the irq set -> irq=1.
REQ-039 Scenario: with STATS_EN, run 3 lines, then nreset=0 mid-fourth -> lines_done=3 before reset, all outputs 0 after reset.

Source files
------------

// File: rtl/hline_sched.sv
// rtl/hline_sched.sv - line-command queue and launch sequencer for the hline z-buffer engine
// Optional statistics counters are built only with `define HLINE_SCHED_STATS_EN.
module hline_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_fb_addr,
  input  logic [31:0] cmd_zbuff_addr,
  input  logic [31:0] cmd_dx,
  input  logic [31:0] cmd_slope,
  input  logic [31:0] cmd_z1,
  input  logic [31:0] cmd_rem,
  input  logic [31:0] cmd_err,
  input  logic [31:0] cmd_rgbx,
  input  logic        flush,
  output logic        eng_start,
  output logic [31:0] eng_fb_addr,
  output logic [31:0] eng_zbuff_addr,
  output logic [31:0] eng_dx,
  output logic [31:0] eng_slope,
  output logic [31:0] eng_z1,
  output logic [31:0] eng_rem,
  output logic [31:0] eng_err,
  output logic [31:0] eng_rgbx,
  input  logic        eng_done,
  output logic        busy,
  output logic [4:0]  q_count,
  output logic        irq,
  input  logic        irq_clr,
  output logic [15:0] lines_done,
  output logic [31:0] busy_cycles
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_nx;
  logic [255:0]  mem [DEPTH];
  logic [255:0]  head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, load, irq_set;

  assign cmd_ready = (q_count < DEPTH_C);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign pop       = (state == WAIT_DONE) && eng_done;
  assign load      = (state == IDLE) && (state_nx == LAUNCH);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (q_count != 5'd0);
  assign irq_set   = pop && !push && (flush || (q_count == 5'd1));

  // WAIT_ACK absorbs a done level left over from the previous line.
  always_comb begin
    state_nx  = state;
    eng_start = 1'b0;
    case (state)
      IDLE:      if ((q_count != 5'd0) && !flush) state_nx = LAUNCH;
      LAUNCH: begin
        eng_start = 1'b1;
        state_nx  = WAIT_ACK;
      end
      WAIT_ACK:  if (!eng_done) state_nx = WAIT_DONE;
      WAIT_DONE: if (eng_done) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope,
                      cmd_z1, cmd_rem, cmd_err, cmd_rgbx};
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_count        <= 5'd0;
      irq            <= 1'b0;
      eng_fb_addr    <= '0;
      eng_zbuff_addr <= '0;
      eng_dx         <= '0;
      eng_slope      <= '0;
      eng_z1         <= '0;
      eng_rem        <= '0;
      eng_err        <= '0;
      eng_rgbx       <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        eng_fb_addr    <= head[255:224];
        eng_zbuff_addr <= head[223:192];
        eng_dx         <= head[191:160];
        eng_slope      <= head[159:128];
        eng_z1         <= head[127:96];
        eng_rem        <= head[95:64];
        eng_err        <= head[63:32];
        eng_rgbx       <= head[31:0];
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      // Flush keeps only a head that is already in flight.
      if (flush) begin
        wr_ptr  <= (state != IDLE) ? rd_ptr + AW'(1) : rd_ptr;
        q_count <= ((state != IDLE) && !pop) ? 5'd1 : 5'd0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        case ({push, pop})
          2'b10:   q_count <= q_count + 5'd1;
          2'b01:   q_count <= q_count - 5'd1;
          default: q_count <= q_count;
        endcase
      end
      if (irq_set)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
    end
  end

`ifdef HLINE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!nreset || irq_clr) begin
      lines_done  <= 16'd0;
      busy_cycles <= 32'd0;
    end else begin
      if (pop && (lines_done != 16'hFFFF))
        lines_done <= lines_done + 16'd1;
      if (busy)
        busy_cycles <= busy_cycles + 32'd1;
    end
  end
`else
  assign lines_done  = 16'd0;
  assign busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hline_sched.sv
// tb/tb_hline_sched.sv - scoreboard bench for hline_sched with a behavioural hline engine model
module tb_hline_sched;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_fb_addr = '0, cmd_zbuff_addr = '0, cmd_dx = '0, cmd_slope = '0;
  logic [31:0] cmd_z1 = '0, cmd_rem = '0, cmd_err = '0, cmd_rgbx = '0;
  logic        flush = 1'b0;
  logic        eng_start;
  logic [31:0] eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope;
  logic [31:0] eng_z1, eng_rem, eng_err, eng_rgbx;
  logic        eng_done;
  logic        busy;
  logic [4:0]  q_count;
  logic        irq;
  logic        irq_clr = 1'b0;
  logic [15:0] lines_done;
  logic [31:0] busy_cycles;

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;
  logic [31:0] exp_dx[$];
  logic [31:0] exp_fb[$];

  int lat = 3;
  int ack_hold = 0;
  bit stall = 1'b0;

  hline_sched #(.DEPTH(4)) dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fb_addr(cmd_fb_addr), .cmd_zbuff_addr(cmd_zbuff_addr), .cmd_dx(cmd_dx),
    .cmd_slope(cmd_slope), .cmd_z1(cmd_z1), .cmd_rem(cmd_rem), .cmd_err(cmd_err),
    .cmd_rgbx(cmd_rgbx), .flush(flush), .eng_start(eng_start),
    .eng_fb_addr(eng_fb_addr), .eng_zbuff_addr(eng_zbuff_addr), .eng_dx(eng_dx),
    .eng_slope(eng_slope), .eng_z1(eng_z1), .eng_rem(eng_rem), .eng_err(eng_err),
    .eng_rgbx(eng_rgbx), .eng_done(eng_done), .busy(busy), .q_count(q_count),
    .irq(irq), .irq_clr(irq_clr), .lines_done(lines_done), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  // Engine model: done is a level that stays high until the next start has been
  // seen for ack_hold cycles, then rises again lat cycles later unless stalled.
  int  ack_cnt = 0;
  int  run_cnt = 0;
  bit  eng_busy = 1'b0;
  always @(negedge clk) begin : engine
    if (!nreset) begin
      eng_done = 1'b0;
      eng_busy = 1'b0;
      ack_cnt  = 0;
      run_cnt  = 0;
    end else if (eng_start) begin
      eng_busy = 1'b1;
      ack_cnt  = ack_hold;
      run_cnt  = lat;
      if (ack_hold == 0) eng_done = 1'b0;
    end else if (eng_busy) begin
      if (ack_cnt > 0) begin
        ack_cnt = ack_cnt - 1;
        if (ack_cnt == 0) eng_done = 1'b0;
      end else if (!stall) begin
        if (run_cnt > 0) run_cnt = run_cnt - 1;
        else begin
          eng_done = 1'b1;
          eng_busy = 1'b0;
        end
      end
    end
  end

  logic        prev_start = 1'b0;
  bit          started = 1'b0;
  logic [31:0] last_dx, last_fb, e_dx, e_fb;
  always @(negedge clk) begin : monitor
    if (!nreset) begin
      prev_start = 1'b0;
      started    = 1'b0;
    end else begin
      if (eng_start) begin
        start_cnt = start_cnt + 1;
        n_checks++;
        if (prev_start) begin
          n_fail++;
          $display("FAIL start_pulse: eng_start high on consecutive cycles, required single cycle");
        end
        n_checks++;
        if (exp_dx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_start: launch of dx=%0d with empty scoreboard, required no launch", eng_dx);
        end else begin
          e_dx = exp_dx.pop_front();
          e_fb = exp_fb.pop_front();
          if (eng_dx !== e_dx || eng_fb_addr !== e_fb || eng_zbuff_addr !== (e_fb ^ 32'h5555_0000) ||
              eng_slope !== e_dx * 3 || eng_z1 !== ~e_fb || eng_rem !== e_dx + 7 ||
              eng_err !== e_fb + e_dx || eng_rgbx !== {e_dx[15:0], e_fb[15:0]}) begin
            n_fail++;
            $display("FAIL descriptor: got dx=%0d fb=%h rgbx=%h, required dx=%0d fb=%h rgbx=%h",
                     eng_dx, eng_fb_addr, eng_rgbx, e_dx, e_fb, {e_dx[15:0], e_fb[15:0]});
          end
        end
        last_dx = eng_dx;
        last_fb = eng_fb_addr;
        started = 1'b1;
      end else if (started) begin
        n_checks++;
        if (eng_dx !== last_dx || eng_fb_addr !== last_fb) begin
          n_fail++;
          $display("FAIL eng_stable: got dx=%0d fb=%h, required dx=%0d fb=%h", eng_dx, eng_fb_addr, last_dx, last_fb);
        end
      end
      prev_start = eng_start;
    end
  end

  task automatic push_cmd(input logic [31:0] dx, input logic [31:0] fb);
    int w;
    w = 0;
    @(negedge clk);
    cmd_dx = dx; cmd_fb_addr = fb; cmd_zbuff_addr = fb ^ 32'h5555_0000; cmd_slope = dx * 3;
    cmd_z1 = ~fb; cmd_rem = dx + 7; cmd_err = fb + dx; cmd_rgbx = {dx[15:0], fb[15:0]};
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 300) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL push_timeout: cmd_ready=%0b, required 1", cmd_ready);
    end else begin
      exp_dx.push_back(dx);
      exp_fb.push_back(fb);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < limit) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b q_count=%0d, required idle", busy, q_count);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; cmd_valid = 1'b0; flush = 1'b0; irq_clr = 1'b0;
    stall = 1'b0; lat = 3; ack_hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_dx.delete();
    exp_fb.delete();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q_count !== 5'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: q_count=%0d ready=%0b busy=%0b irq=%0b, required 0 1 0 0", q_count, cmd_ready, busy, irq);
    end
    n_checks++;
    if (eng_start !== 1'b0 || eng_fb_addr !== 32'd0 || eng_dx !== 32'd0 || eng_rgbx !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_eng: start=%0b fb=%h dx=%h rgbx=%h, required all 0", eng_start, eng_fb_addr, eng_dx, eng_rgbx);
    end
    n_checks++;
    if (lines_done !== 16'd0 || busy_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: lines_done=%0d busy_cycles=%0d, required 0 0", lines_done, busy_cycles);
    end
    nreset = 1'b1;
  endtask

  task automatic test_single_line();
    int s0;
    do_reset();
    lat = 20;
    s0 = start_cnt;
    push_cmd(32'd300, 32'h1000);
    @(negedge clk);
    n_checks++;
    if (eng_start !== 1'b0 || q_count !== 5'd1) begin
      n_fail++;
      $display("FAIL latency_n1: eng_start=%0b q_count=%0d, required 0 1", eng_start, q_count);
    end
    @(negedge clk);
    n_checks++;
    if (eng_start !== 1'b1 || eng_fb_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL latency_n2: eng_start=%0b fb=%h, required 1 00001000", eng_start, eng_fb_addr);
    end
    wait_idle(100);
    n_checks++;
    if (irq !== 1'b1 || q_count !== 5'd0 || eng_fb_addr !== 32'h1000 || start_cnt != s0 + 1) begin
      n_fail++;
      $display("FAIL single_done: irq=%0b q_count=%0d fb=%h starts=%0d, required 1 0 00001000 %0d",
               irq, q_count, eng_fb_addr, start_cnt - s0, 1);
    end
    @(negedge clk) irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%0b, required 0", irq);
    end
    lat = 3;
    push_cmd(32'd0, 32'h2000);
    wait_idle(100);
    n_checks++;
    if (start_cnt != s0 + 2 || q_count !== 5'd0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL dx_zero: starts=%0d q_count=%0d irq=%0b, required 2 0 1", start_cnt - s0, q_count, irq);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    stall = 1'b1;
    s0 = start_cnt;
    for (int i = 1; i <= 4; i++) push_cmd(32'(i), 32'h4000 + 32'(i * 16));
    @(negedge clk);
    n_checks++;
    if (q_count !== 5'd4 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL queue_full: q_count=%0d ready=%0b, required 4 0", q_count, cmd_ready);
    end
    fork
      push_cmd(32'd5, 32'h4050);
      begin
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (q_count !== 5'd4 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: q_count=%0d ready=%0b, required 4 0", q_count, cmd_ready);
          end
        end
        stall = 1'b0;
      end
    join
    wait_idle(300);
    n_checks++;
    if (start_cnt != s0 + 5 || exp_dx.size() != 0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL five_lines: starts=%0d pending=%0d irq=%0b, required 5 0 1", start_cnt - s0, exp_dx.size(), irq);
    end
  endtask

  task automatic test_done_held();
    int s0;
    int w;
    do_reset();
    lat = 2;
    ack_hold = 4;
    s0 = start_cnt;
    push_cmd(32'd11, 32'h5000);
    push_cmd(32'd12, 32'h5100);
    w = 0;
    @(negedge clk);
    #1;
    while (start_cnt < s0 + 2 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    n_checks++;
    if (start_cnt != s0 + 2) begin
      n_fail++;
      $display("FAIL second_launch: starts=%0d, required 2", start_cnt - s0);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (q_count !== 5'd1) begin
        n_fail++;
        $display("FAIL wait_ack: q_count=%0d while done still high, required 1", q_count);
      end
    end
    wait_idle(100);
    n_checks++;
    if (start_cnt != s0 + 2 || q_count !== 5'd0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL done_held_end: starts=%0d q_count=%0d irq=%0b, required 2 0 1", start_cnt - s0, q_count, irq);
    end
  endtask

  task automatic test_flush();
    int s0;
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_cmd(32'(20 + i), 32'h6000 + 32'(i));
    @(negedge clk);
    flush = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    exp_dx.delete();
    exp_fb.delete();
    @(negedge clk);
    n_checks++;
    if (q_count !== 5'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_inflight: q_count=%0d busy=%0b, required 1 1", q_count, busy);
    end
    s0 = start_cnt;
    stall = 1'b0;
    wait_idle(100);
    repeat (10) @(negedge clk);
    n_checks++;
    if (q_count !== 5'd0 || irq !== 1'b1 || start_cnt != s0) begin
      n_fail++;
      $display("FAIL flush_drain: q_count=%0d irq=%0b extra_starts=%0d, required 0 1 0", q_count, irq, start_cnt - s0);
    end
    @(negedge clk);
    cmd_dx = 32'd99;
    cmd_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    flush = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (q_count !== 5'd0 || start_cnt != s0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_push: q_count=%0d starts=%0d busy=%0b, required 0 0 0", q_count, start_cnt - s0, busy);
    end
  endtask

  task automatic test_irq_clr_coincide();
    int w;
    do_reset();
    lat = 5;
    push_cmd(32'd7, 32'h3000);
    w = 0;
    @(negedge clk);
    #1;
    while (eng_done !== 1'b1 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    n_checks++;
    if (irq !== 1'b1 || q_count !== 5'd0) begin
      n_fail++;
      $display("FAIL irq_set_wins: irq=%0b q_count=%0d, required 1 0", irq, q_count);
    end
    @(negedge clk) irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr_alone: irq=%0b, required 0", irq);
    end
  endtask

  task automatic test_stats_reset();
    int s0;
    int w;
    do_reset();
    for (int i = 1; i <= 3; i++) push_cmd(32'(30 + i), 32'h7000 + 32'(i));
    wait_idle(200);
    n_checks++;
`ifdef HLINE_SCHED_STATS_EN
    if (lines_done !== 16'd3 || busy_cycles == 32'd0) begin
      n_fail++;
      $display("FAIL stats_count: lines_done=%0d busy_cycles=%0d, required 3 and nonzero", lines_done, busy_cycles);
    end
`else
    if (lines_done !== 16'd0 || busy_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_off: lines_done=%0d busy_cycles=%0d, required 0 0", lines_done, busy_cycles);
    end
`endif
    s0 = start_cnt;
    lat = 30;
    push_cmd(32'd34, 32'h7004);
    w = 0;
    @(negedge clk);
    #1;
    while (start_cnt == s0 && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q_count !== 5'd0 || busy !== 1'b0 || irq !== 1'b0 || eng_start !== 1'b0 ||
        eng_fb_addr !== 32'd0 || eng_dx !== 32'd0 || eng_err !== 32'd0 ||
        lines_done !== 16'd0 || busy_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL midline_reset: q_count=%0d busy=%0b irq=%0b fb=%h dx=%0d lines=%0d cycles=%0d, required all 0",
               q_count, busy, irq, eng_fb_addr, eng_dx, lines_done, busy_cycles);
    end
    exp_dx.delete();
    exp_fb.delete();
    s0 = start_cnt;
    nreset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (start_cnt != s0 || irq !== 1'b0 || q_count !== 5'd0) begin
      n_fail++;
      $display("FAIL after_reset: starts=%0d irq=%0b q_count=%0d, required 0 0 0", start_cnt - s0, irq, q_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_done_held();
    test_flush();
    test_irq_clr_coincide();
    test_stats_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
